// File: rtl/bram_sd_sequencer.sv
// Streams 2^SECTOR_BITS backup-RAM sectors between BRAM and the hps_io SD interface; starts register one cycle after the trigger.
// Flow control is the sd_rd/sd_wr vs sd_ack handshake; stalled acks abort after ACK_TIMEOUT cycles and late requests are dropped.
module bram_sd_sequencer #(
  parameter int SECTOR_BITS = 7,
  parameter int SLOT_BITS   = 2,
  parameter int ACK_TIMEOUT = 50000000
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 cart_download,
  input  logic                 img_mounted,
  input  logic                 img_readonly,
  input  logic [63:0]          img_size,
  input  logic                 osd_status,
  input  logic                 autosave_en,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic                 bram_change,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  output logic                 bk_ena,
  output logic                 bk_loading,
  output logic                 busy,
  output logic                 sav_pending,
  output logic                 error,
  output logic                 done
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t                 r_state;
  logic                   r_cart_q;
  logic                   r_load_q;
  logic                   r_save_q;
  logic                   r_ack_q;
  logic                   r_auto_q;
  logic                   r_is_load;
  logic [SLOT_BITS-1:0]   r_slot;
  logic [SECTOR_BITS-1:0] r_idx;
  logic [TW-1:0]          r_tmo;
  logic                   r_sd_rd;
  logic                   r_sd_wr;
  logic                   r_bk_ena;
  logic                   r_bk_loading;
  logic                   r_busy;
  logic                   r_sav_pending;
  logic                   r_error;
  logic                   r_done;

  logic w_cart_rise;
  logic w_cart_fall;
  logic w_load_rise;
  logic w_save_rise;
  logic w_auto;
  logic w_auto_rise;
  logic w_ack_rise;
  logic w_ack_fall;
  logic w_can_start;
  logic w_start_load;
  logic w_start_save;
  logic w_start;
  logic w_tmo_hit;

  assign w_cart_rise = cart_download & ~r_cart_q;
  assign w_cart_fall = ~cart_download & r_cart_q;
  assign w_load_rise = load_req & ~r_load_q;
  assign w_save_rise = save_req & ~r_save_q;
  assign w_auto      = r_sav_pending & osd_status & autosave_en;
  assign w_auto_rise = w_auto & ~r_auto_q;
  assign w_ack_rise  = sd_ack & ~r_ack_q;
  assign w_ack_fall  = ~sd_ack & r_ack_q;

  // A download starting in the same cycle invalidates the image, so nothing may start.
  assign w_can_start  = (r_state == IDLE) & r_bk_ena & ~w_cart_rise;
  assign w_start_load = w_can_start & ((w_cart_fall & (img_size != 64'd0)) | w_load_rise);
  assign w_start_save = w_can_start & ~w_start_load & (w_save_rise | w_auto_rise);
  assign w_start      = w_start_load | w_start_save;
  assign w_tmo_hit    = (r_tmo == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cart_q      <= 1'b0;
      r_load_q      <= 1'b0;
      r_save_q      <= 1'b0;
      r_ack_q       <= 1'b0;
      r_auto_q      <= 1'b0;
      r_is_load     <= 1'b0;
      r_slot        <= '0;
      r_idx         <= '0;
      r_tmo         <= '0;
      r_sd_rd       <= 1'b0;
      r_sd_wr       <= 1'b0;
      r_bk_ena      <= 1'b0;
      r_bk_loading  <= 1'b0;
      r_busy        <= 1'b0;
      r_sav_pending <= 1'b0;
      r_error       <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_cart_q <= cart_download;
      r_load_q <= load_req;
      r_save_q <= save_req;
      r_ack_q  <= sd_ack;
      r_auto_q <= w_auto;
      r_done   <= 1'b0;

      if (w_cart_rise) r_bk_ena <= 1'b0;
      if (cart_download & img_mounted & ~img_readonly) r_bk_ena <= 1'b1;

      if (bram_change & ~osd_status) r_sav_pending <= 1'b1;
      if (w_start) r_sav_pending <= 1'b0;

      if (r_state != IDLE && w_cart_rise) begin
        // Abort: error keeps whatever the operation had (always 0 mid-op).
        r_sd_rd      <= 1'b0;
        r_sd_wr      <= 1'b0;
        r_bk_loading <= 1'b0;
        r_busy       <= 1'b0;
        r_state      <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              r_slot       <= slot;
              r_idx        <= '0;
              r_is_load    <= w_start_load;
              r_sd_rd      <= w_start_load;
              r_sd_wr      <= ~w_start_load;
              r_bk_loading <= w_start_load;
              r_busy       <= 1'b1;
              r_error      <= 1'b0;
              r_tmo        <= '0;
              r_state      <= REQ;
            end
          end
          REQ: begin
            if (w_ack_rise) begin
              r_sd_rd <= 1'b0;
              r_sd_wr <= 1'b0;
              r_tmo   <= '0;
              r_state <= XFER;
            end else if (w_tmo_hit) begin
              r_sd_rd      <= 1'b0;
              r_sd_wr      <= 1'b0;
              r_bk_loading <= 1'b0;
              r_busy       <= 1'b0;
              r_error      <= 1'b1;
              r_state      <= IDLE;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          XFER: begin
            if (w_ack_fall) begin
              r_tmo <= '0;
              if (&r_idx) begin
                r_busy       <= 1'b0;
                r_bk_loading <= 1'b0;
                r_done       <= 1'b1;
                r_state      <= IDLE;
              end else begin
                r_idx   <= r_idx + SECTOR_BITS'(1);
                r_sd_rd <= r_is_load;
                r_sd_wr <= ~r_is_load;
                r_state <= REQ;
              end
            end else if (w_tmo_hit) begin
              r_bk_loading <= 1'b0;
              r_busy       <= 1'b0;
              r_error      <= 1'b1;
              r_state      <= IDLE;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Slot and index are separate fields, so the index can never carry into the slot.
  assign sd_lba      = 32'({r_slot, r_idx});
  assign sd_rd       = r_sd_rd;
  assign sd_wr       = r_sd_wr;
  assign bk_ena      = r_bk_ena;
  assign bk_loading  = r_bk_loading;
  assign busy        = r_busy;
  assign sav_pending = r_sav_pending;
  assign error       = r_error;
  assign done        = r_done;

endmodule

// File: doc/bram_sd_sequencer.md
Name: bram_sd_sequencer

Overview:
- Parametrised backup-RAM save/load sequencer between the cartridge BRAM and the hps_io SD sector interface.
- Streams 2^SECTOR_BITS consecutive 512-byte sectors per operation, selected from one of 2^SLOT_BITS save slots.
- Handles the following:
  - Auto-load after cart download.
  - OSD-triggered autosave.
  - Manual load/save.
  - Ack timeout with a sticky error flag.
  - Abort on a new cart download.
- Sits in emu beside hps_io; its bk_loading output is ORed into the system reset.

Parameters:
SECTOR_BITS, 7, log2 of sectors per save image (7 = 64 KiB)
SLOT_BITS, 2, log2 of save slots; LBA base = slot << SECTOR_BITS
ACK_TIMEOUT, 50000000, clk_sys cycles allowed per sd_ack edge before abort

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cart_download  in  1  cart ROM download in progress
img_mounted  in  1  pulse: save image mounted
img_readonly  in  1  mounted image is read-only
img_size  in  64  mounted image size in bytes
osd_status  in  1  OSD open
autosave_en  in  1  autosave option
load_req  in  1  manual load (level, rising edge used)
save_req  in  1  manual save (level, rising edge used)
slot  in  SLOT_BITS  slot for the next operation
bram_change  in  1  pulse: BRAM written by game
sd_lba  out  32  sector address
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
sd_ack  in  1  hps_io sector ack
bk_ena  out  1  save image usable
bk_loading  out  1  load in progress (hold system in reset)
busy  out  1  operation in progress
sav_pending  out  1  unsaved BRAM changes
error  out  1  sticky: last operation timed out
done  out  1  1-cycle pulse on successful completion

Behaviour:
- Reset (async, reset_n=0): every output is 0 and the FSM is in IDLE. All inputs are sampled on clk_sys; edge detectors use registered copies that reset to 0.
- bk_ena:
  - Cleared on the rising edge of cart_download.
  - Set in any cycle where cart_download & img_mounted & ~img_readonly.
- sav_pending:
  - Set by bram_change while ~osd_status.
  - Cleared when any operation starts. If both happen in the same cycle, the clear wins.
- FSM states: IDLE, REQ, XFER.
- Start conditions, checked only in IDLE with bk_ena=1, in priority order:
  1. Falling edge of cart_download with img_size != 0 → load.
  2. Rising edge of load_req → load.
  3. Rising edge of save_req → save.
  4. Rising edge of (sav_pending & osd_status & autosave_en) → save.
- Requests that arrive when not in IDLE, or when bk_ena=0, are dropped, not queued.
- Operation start, registered in the cycle after the detecting edge:
  - Latch slot.
  - Sector index idx = 0.
  - sd_lba = zero-extended {slot_latched, idx}.
  - Load: sd_rd=1, bk_loading=1. Save: sd_wr=1.
  - busy=1, error=0.
  - Go to REQ.
- REQ: on a rising sd_ack, drop sd_rd/sd_wr and go to XFER.
- XFER, on a falling sd_ack:
  - If idx is all ones: busy=0, bk_loading=0, done=1 for one cycle, go to IDLE.
  - Otherwise: idx+1, update sd_lba, re-assert the same request, go to REQ.
- Timeout:
  - The counter resets on every REQ/XFER entry.
  - If it reaches ACK_TIMEOUT: sd_rd=sd_wr=0, bk_loading=0, busy=0, error=1, go to IDLE, no done.
- Rising edge of cart_download during an operation: abort to IDLE as above but with error unchanged, and bk_ena cleared.
- idx is SECTOR_BITS wide and never wraps into the slot field. sd_lba upper bits are always 0.

Test Plan:
- Auto-load, SECTOR_BITS=2, slot=1:
  - Stimulus: img_mounted pulse during download, cart_download falls, img_size=65536; responder acks 3 cycles after each request.
  - Required: sd_rd pulses with sd_lba=4,5,6,7; bk_loading high throughout; done pulses once; bk_loading=0 afterwards.
- Manual save:
  - Stimulus: save_req rising with slot=0.
  - Required: sd_wr pulses at lba 0..3; sd_rd never high; sav_pending cleared at start.
- Autosave:
  - Stimulus: bram_change with osd_status=0, then osd_status=1 with autosave_en=1.
  - Required: sav_pending=1, then a save starts the cycle after osd_status rises; with autosave_en=0, no save and sav_pending stays 1.
- Timeout, ACK_TIMEOUT=16:
  - Stimulus: responder never acks sector 2.
  - Required: after 16 cycles sd_rd=0, busy=0, error=1, no done; the next load_req clears error.
- Abort and gating:
  - Stimulus: cart_download rises mid-save.
  - Required: sd_wr=0, busy=0, error unchanged, bk_ena=0; a subsequent load_req is ignored until remount.
- Priority and reset:
  - Stimulus: load_req and save_req rise in the same cycle.
  - Required: load performed; save_req edge during busy ignored; reset_n low mid-operation drives every output to 0 immediately.
